// File: rtl/z80_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM.
//   a_* / b_*    : requester ports (req/addr/we/wdata in, ack/rvalid/rdata out)
//   mem_*        : single-port RAM drive and registered read data
//   conflict_cnt : saturating count of cycles with both requests high
// Modport slave is the arbiter's view; master is the environment's view.
interface z80_mem_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_we;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  a_req, a_addr, a_we, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_addr, b_we, b_wdata,
    output b_ack, b_rvalid, b_rdata,
    output mem_address, mem_we, mem_wdata,
    input  mem_rdata,
    output conflict_cnt
  );

  modport master (
    output a_req, a_addr, a_we, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_addr, b_we, b_wdata,
    input  b_ack, b_rvalid, b_rdata,
    input  mem_address, mem_we, mem_wdata,
    output mem_rdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/z80_mem_arbiter.sv
// Two-port arbiter in front of a single-port 64K x 8 RAM with registered read.
// Port A (CPU) has priority; port B (DMA/video) is forced through after it has
// been refused MAX_WAIT consecutive cycles. Read data is routed back to the
// port that issued the read, one cycle after the grant.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : z80_mem_arbiter_if.slave (requester ports, RAM drive, stats)
module z80_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  z80_mem_arbiter_if.slave    bus
);
  localparam int unsigned WAIT_W     = 4;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  grant_e              grant;
  logic [WAIT_W-1:0]   b_wait;
  logic                a_rvalid_q;
  logic                b_rvalid_q;
  logic [CNT_W-1:0]    conflict_q;

  // Grant selection: starving B first, then A, then B.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (bus.b_req && (b_wait >= WAIT_LIMIT)) begin
        grant = GNT_B;
      end else if (bus.a_req) begin
        grant = GNT_A;
      end else if (bus.b_req) begin
        grant = GNT_B;
      end
    end
  end

  // Ack and RAM drive; address/wdata default to port A when B is not granted.
  always_comb begin
    bus.a_ack       = 1'b0;
    bus.b_ack       = 1'b0;
    bus.mem_address = bus.a_addr;
    bus.mem_wdata   = bus.a_wdata;
    bus.mem_we      = 1'b0;
    case (grant)
      GNT_A: begin
        bus.a_ack  = 1'b1;
        bus.mem_we = bus.a_we;
      end
      GNT_B: begin
        bus.b_ack       = 1'b1;
        bus.mem_address = bus.b_addr;
        bus.mem_wdata   = bus.b_wdata;
        bus.mem_we      = bus.b_we;
      end
      default: ;
    endcase
  end

  // Read-return tracking, B starvation counter and conflict statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_wait     <= '0;
      conflict_q <= '0;
    end else begin
      a_rvalid_q <= (grant == GNT_A) && !bus.a_we;
      b_rvalid_q <= (grant == GNT_B) && !bus.b_we;

      if (!bus.b_req || (grant == GNT_B)) begin
        b_wait <= '0;
      end else if (b_wait < WAIT_LIMIT) begin
        b_wait <= b_wait + WAIT_W'(1);
      end

      if (bus.a_req && bus.b_req && (conflict_q != '1)) begin
        conflict_q <= conflict_q + CNT_W'(1);
      end
    end
  end

  // A read granted just before reset must not report valid during reset.
  assign bus.a_rvalid     = a_rvalid_q && !reset;
  assign bus.b_rvalid     = b_rvalid_q && !reset;
  assign bus.a_rdata      = bus.mem_rdata;
  assign bus.b_rdata      = bus.mem_rdata;
  assign bus.conflict_cnt = conflict_q;
endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Self-checking bench for z80_mem_arbiter: a per-cycle vector table followed
// by hand-written contention, reset and saturation sequences.
module tb_z80_mem_arbiter;
  localparam int unsigned CNT_W = 16;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  z80_mem_arbiter_if #(.CNT_W(CNT_W)) bus ();

  z80_mem_arbiter #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: synchronous write, registered read (read-before-write).
  logic [7:0] ram [0:65535];
  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_address];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        a_req;
    logic [15:0] a_addr;
    logic        a_we;
    logic [7:0]  a_wdata;
    logic        b_req;
    logic [15:0] b_addr;
    logic        b_we;
    logic [7:0]  b_wdata;
    logic        x_a_ack;
    logic        x_b_ack;
    logic        x_we;
    logic [15:0] x_addr;
    logic        x_a_rv;
    logic        x_b_rv;
    logic [7:0]  x_rdata;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(
    input logic ar, input logic [15:0] aa, input logic aw, input logic [7:0] ad,
    input logic br, input logic [15:0] ba, input logic bw, input logic [7:0] bd,
    input logic xaa, input logic xba, input logic xwe, input logic [15:0] xad,
    input logic xar, input logic xbr, input logic [7:0] xrd, input logic [15:0] xc);
    vec_t v;
    v.a_req = ar;  v.a_addr = aa;  v.a_we = aw;  v.a_wdata = ad;
    v.b_req = br;  v.b_addr = ba;  v.b_we = bw;  v.b_wdata = bd;
    v.x_a_ack = xaa; v.x_b_ack = xba; v.x_we = xwe; v.x_addr = xad;
    v.x_a_rv = xar;  v.x_b_rv = xbr;  v.x_rdata = xrd; v.x_cnt = xc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ar, input logic [15:0] aa, input logic aw, input logic [7:0] ad,
                       input logic br, input logic [15:0] ba, input logic bw, input logic [7:0] bd);
    bus.a_req = ar; bus.a_addr = aa; bus.a_we = aw; bus.a_wdata = ad;
    bus.b_req = br; bus.b_addr = ba; bus.b_we = bw; bus.b_wdata = bd;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
    ram[16'h1234] = 8'h5A;
    ram[16'h8000] = 8'h11;
    ram[16'h8001] = 8'h22;
    ram[16'h8002] = 8'h33;
    ram[16'h8003] = 8'h44;
    ram[16'h0030] = 8'h3C;
    ram[16'h0040] = 8'h4D;

    //            a_req addr     we  wd     b_req addr     we  wd     aack back we  addr     arv brv rdata  cnt
    vecs[0]  = mk(1, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 0, 16'h1234, 0, 0, 8'h00, 16'd0);
    vecs[1]  = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 8'h5A, 16'd0);
    vecs[2]  = mk(1, 16'h0010, 1, 8'h77, 0, 16'h0000, 0, 8'h00, 1, 0, 1, 16'h0010, 0, 0, 8'h00, 16'd0);
    vecs[3]  = mk(1, 16'h0010, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 0, 16'h0010, 0, 0, 8'h00, 16'd0);
    vecs[4]  = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 8'h77, 16'd0);
    vecs[5]  = mk(0, 16'h0000, 0, 8'h00, 1, 16'h8000, 0, 8'h00, 0, 1, 0, 16'h8000, 0, 0, 8'h00, 16'd0);
    vecs[6]  = mk(0, 16'h0000, 0, 8'h00, 1, 16'h8001, 0, 8'h00, 0, 1, 0, 16'h8001, 0, 1, 8'h11, 16'd0);
    vecs[7]  = mk(0, 16'h0000, 0, 8'h00, 1, 16'h8002, 0, 8'h00, 0, 1, 0, 16'h8002, 0, 1, 8'h22, 16'd0);
    vecs[8]  = mk(0, 16'h0000, 0, 8'h00, 1, 16'h8003, 0, 8'h00, 0, 1, 0, 16'h8003, 0, 1, 8'h33, 16'd0);
    vecs[9]  = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 8'h44, 16'd0);
    vecs[10] = mk(0, 16'h0000, 0, 8'h00, 1, 16'h0020, 1, 8'hC3, 0, 1, 1, 16'h0020, 0, 0, 8'h00, 16'd0);
    vecs[11] = mk(1, 16'h0020, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 0, 16'h0020, 0, 0, 8'h00, 16'd0);
    vecs[12] = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 8'hC3, 16'd0);
    vecs[13] = mk(1, 16'h0030, 0, 8'h00, 1, 16'h0040, 0, 8'h00, 1, 0, 0, 16'h0030, 0, 0, 8'h00, 16'd0);
    vecs[14] = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 8'h3C, 16'd1);
    vecs[15] = mk(0, 16'h0000, 0, 8'h00, 1, 16'h0040, 0, 8'h00, 0, 1, 0, 16'h0040, 0, 0, 8'h00, 16'd1);
    vecs[16] = mk(0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 8'h4D, 16'd1);

    // Reset state with both requests asserted: nothing may be granted.
    reset = 1'b1;
    drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 16'h0200, 1'b0, 8'h00);
    step();
    step();
    #3;
    chk("rst_a_ack", 32'(bus.a_ack), 32'd0);
    chk("rst_b_ack", 32'(bus.b_ack), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
    chk("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
    drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    step();
    reset = 1'b0;

    // Vector table: one row per cycle, combinational and registered outputs.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].a_req, vecs[i].a_addr, vecs[i].a_we, vecs[i].a_wdata,
            vecs[i].b_req, vecs[i].b_addr, vecs[i].b_we, vecs[i].b_wdata);
      #3;
      chk($sformatf("v%0d_a_ack", i), 32'(bus.a_ack), 32'(vecs[i].x_a_ack));
      chk($sformatf("v%0d_b_ack", i), 32'(bus.b_ack), 32'(vecs[i].x_b_ack));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].x_we));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_address), 32'(vecs[i].x_addr));
      chk($sformatf("v%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(vecs[i].x_a_rv));
      chk($sformatf("v%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(vecs[i].x_b_rv));
      if (vecs[i].x_a_rv) chk($sformatf("v%0d_a_rdata", i), 32'(bus.a_rdata), 32'(vecs[i].x_rdata));
      if (vecs[i].x_b_rv) chk($sformatf("v%0d_b_rdata", i), 32'(bus.b_rdata), 32'(vecs[i].x_rdata));
      chk($sformatf("v%0d_cnt", i), 32'(bus.conflict_cnt), 32'(vecs[i].x_cnt));
      step();
    end

    // Continuous contention: grant pattern AAAAB, rvalid follows the granter.
    do_reset();
    drive(1'b1, 16'h0100, 1'b0, 8'h00, 1'b1, 16'h0200, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      logic exp_b;
      logic prev_b;
      exp_b  = ((i % 5) == 4);
      prev_b = (i > 0) && (((i - 1) % 5) == 4);
      #3;
      chk($sformatf("arb%0d_a_ack", i), 32'(bus.a_ack), 32'(!exp_b));
      chk($sformatf("arb%0d_b_ack", i), 32'(bus.b_ack), 32'(exp_b));
      chk($sformatf("arb%0d_addr", i), 32'(bus.mem_address), exp_b ? 32'h0200 : 32'h0100);
      chk($sformatf("arb%0d_a_rv", i), 32'(bus.a_rvalid), 32'((i > 0) && !prev_b));
      chk($sformatf("arb%0d_b_rv", i), 32'(bus.b_rvalid), 32'(prev_b));
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    #3;
    chk("arb_cnt10", 32'(bus.conflict_cnt), 32'd10);
    step();

    // Reset one cycle after an A read grant, with B partly starved.
    do_reset();
    drive(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 16'h0200, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("pre%0d_a_ack", i), 32'(bus.a_ack), 32'd1);
      step();
    end
    reset = 1'b1;
    #3;
    chk("mid_a_ack", 32'(bus.a_ack), 32'd0);
    chk("mid_b_ack", 32'(bus.b_ack), 32'd0);
    chk("mid_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      if (i == 0) begin
        chk("post_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("post_cnt", 32'(bus.conflict_cnt), 32'd0);
      end
      chk($sformatf("post%0d_a_ack", i), 32'(bus.a_ack), 32'(i != 4));
      chk($sformatf("post%0d_b_ack", i), 32'(bus.b_ack), 32'(i == 4));
      step();
    end

    // Conflict counter saturates at all-ones without wrapping.
    do_reset();
    drive(1'b1, 16'h0100, 1'b0, 8'h00, 1'b1, 16'h0200, 1'b0, 8'h00);
    repeat (65534) step();
    #3;
    chk("sat_cnt_fffe", 32'(bus.conflict_cnt), 32'h0000FFFE);
    repeat (7) step();
    #3;
    chk("sat_cnt_ffff", 32'(bus.conflict_cnt), 32'h0000FFFF);
    drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Read returns must never target both ports in the same cycle.
  always @(negedge clock) begin
    if (bus.a_rvalid && bus.b_rvalid) begin
      n_checks++;
      n_errors++;
      $display("FAIL rvalid_excl: got a=1 b=1 want at most one (t=%0t)", $time);
    end
  end
endmodule
